// File: rtl/sid_pkg.sv
// Shared constants and types for the SID host-bus interface and register file.
package sid_pkg;

    localparam int         NUM_WR_REGS  = 25;
    localparam logic [4:0] LAST_WR_ADDR = 5'(NUM_WR_REGS - 1);

    localparam logic [4:0] ADDR_POTX = 5'd25;
    localparam logic [4:0] ADDR_POTY = 5'd26;
    localparam logic [4:0] ADDR_OSC3 = 5'd27;
    localparam logic [4:0] ADDR_ENV3 = 5'd28;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        ACTIVE,
        COMMIT
    } bus_state_t;

    // Bus fields captured during phi2-high, acted on one cycle after phi2 falls.
    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
        logic       cs_n;
        logic       rw;
    } bus_shadow_t;

    function automatic logic is_wr_addr(input logic [4:0] a);
        return a <= LAST_WR_ADDR;
    endfunction

endpackage

// File: rtl/sid_sync.sv
// N-stage single-bit synchronizer for asynchronous host-bus control lines.
module sid_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignment so every stage samples its pre-edge neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sid_bus_if.sv
// 6502-style host bus to clk-domain bridge: write strobes for regFile and
// read-back with a decaying open-bus latch.
module sid_bus_if
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DECAY_CYCLES = 2000000,
    parameter int DECAY_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2,
    input  logic       cs_n,
    input  logic       rw,
    input  logic [4:0] addr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] potx,
    input  logic [7:0] poty,
    input  logic [7:0] osc3,
    input  logic [7:0] env3,
    output logic       w_en,
    output logic [4:0] w_addr,
    output logic [7:0] w_data
);

    localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_CYCLES);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(1);

    logic phi2_s;
    logic cs_s;
    logic rw_s;

    sid_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_phi2 (
        .clk (clk),
        .rst (rst),
        .d   (phi2),
        .q   (phi2_s)
    );

    sid_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_s)
    );

    sid_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
        .clk (clk),
        .rst (rst),
        .d   (rw),
        .q   (rw_s)
    );

    // The phi2 chain resets low, so its output only reflects the real pin
    // once it has been refilled; WAIT_LOW must not trust it before then.
    logic [SYNC_STAGES-1:0] flush;
    logic                   sync_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush <= '0;
        end else begin
            flush <= {flush[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_live = flush[SYNC_STAGES-1];

    bus_state_t  state;
    bus_state_t  next_state;
    bus_shadow_t shadow;
    logic        shadow_load;
    logic        commit_wr;
    logic        commit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOW;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOW: if (sync_live && !phi2_s) next_state = IDLE;
            IDLE:     if (phi2_s)               next_state = ACTIVE;
            ACTIVE:   if (!phi2_s)              next_state = COMMIT;
            COMMIT:                             next_state = IDLE;
            default:                            next_state = WAIT_LOW;
        endcase
    end

    always_comb begin
        shadow_load = (state == ACTIVE);
        commit_wr   = (state == COMMIT) && !shadow.cs_n && !shadow.rw;
        commit_reg  = commit_wr && is_wr_addr(shadow.addr);
        d_oe        = (state == ACTIVE) && !cs_s && rw_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '{addr: 5'd0, data: 8'h00, cs_n: 1'b1, rw: 1'b1};
        end else if (shadow_load) begin
            shadow <= '{addr: addr, data: d_in, cs_n: cs_s, rw: rw_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en   <= 1'b0;
            w_addr <= 5'd0;
            w_data <= 8'h00;
        end else begin
            w_en <= commit_reg;
            if (commit_reg) begin
                w_addr <= shadow.addr;
                w_data <= shadow.data;
            end
        end
    end

    logic [7:0]         bus_latch;
    logic [DECAY_W-1:0] decay_cnt;

    // A write in the expiry cycle takes precedence over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_latch <= 8'h00;
            decay_cnt <= '0;
        end else if (commit_wr) begin
            bus_latch <= shadow.data;
            decay_cnt <= DECAY_LOAD;
        end else if (decay_cnt != '0) begin
            decay_cnt <= decay_cnt - DECAY_LAST;
            if (decay_cnt == DECAY_LAST) begin
                bus_latch <= 8'h00;
            end
        end
    end

    logic [7:0] rd_data;

    always_comb begin
        case (addr)
            ADDR_POTX: rd_data = potx;
            ADDR_POTY: rd_data = poty;
            ADDR_OSC3: rd_data = osc3;
            ADDR_ENV3: rd_data = env3;
            default:   rd_data = bus_latch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= 8'h00;
        end else if (state == ACTIVE) begin
            d_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_sid_bus_if.sv
// Scoreboard bench for sid_bus_if: stimulus predicts strobes and read data,
// a negedge monitor compares whatever the DUT presents.
module tb_sid_bus_if;

    localparam int SYNC  = 2;
    localparam int DECAY = 8;
    localparam int DW    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       phi2;
    logic       cs_n;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] potx, poty, osc3, env3;
    logic       w_en;
    logic [4:0] w_addr;
    logic [7:0] w_data;

    sid_bus_if #(.SYNC_STAGES(SYNC), .DECAY_CYCLES(DECAY), .DECAY_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .phi2   (phi2),
        .cs_n   (cs_n),
        .rw     (rw),
        .addr   (addr),
        .d_in   (d_in),
        .d_out  (d_out),
        .d_oe   (d_oe),
        .potx   (potx),
        .poty   (poty),
        .osc3   (osc3),
        .env3   (env3),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp_v);
        end
    endtask

    // Reference model: expected write strobes, the open-bus latch as a value
    // plus the cycle it was loaded, and the window in which d_oe must be high.
    typedef struct {
        int addr;
        int data;
        int when;
    } wr_t;

    wr_t exp_q[$];
    int  lat_val = 0;
    int  lat_at  = -1000;
    bit  rd_on   = 1'b0;
    int  oe_lo   = 1;
    int  oe_hi   = 0;

    function automatic int latch_after(input int n);
        return (n - lat_at < DECAY) ? lat_val : 0;
    endfunction

    function automatic int read_model(input int a, input int n);
        case (a)
            25:      return int'(potx);
            26:      return int'(poty);
            27:      return int'(osc3);
            28:      return int'(env3);
            default: return latch_after(n);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One host bus cycle: phi2 high for hi clks, then low for lo clks (lo >= 4).
    // If chg_at >= 0, osc3 changes to new_osc that many clks into the high phase.
    task automatic bus_cycle(input bit rw_i, input bit cs_n_i, input int a, input int d,
                             input int hi, input int lo, input int chg_at, input int new_osc);
        int s;
        int k;
        step();
        s     = cyc;
        k     = s + hi;
        rw    = rw_i;
        cs_n  = cs_n_i;
        addr  = 5'(a);
        d_in  = 8'(d);
        phi2  = 1'b1;
        rd_on = rw_i && !cs_n_i;
        oe_lo = s + SYNC + 1;
        oe_hi = k + SYNC;
        if (!rw_i && !cs_n_i) begin
            lat_val = d;
            lat_at  = k + SYNC + 2;
            if (a <= 24) exp_q.push_back('{addr: a, data: d, when: k + SYNC + 2});
        end
        for (int i = 0; i < hi; i++) begin
            if (i == chg_at) osc3 = 8'(new_osc);
            step();
        end
        phi2 = 1'b0;
        repeat (lo - 1) step();
    endtask

    bit prev_oe  = 1'b0;
    int prev_exp = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_oe = 1'b0;
        end else begin
            check("d_oe", 32'(d_oe), 32'(rd_on && cyc >= oe_lo && cyc <= oe_hi));
            if (d_oe && prev_oe) check("d_out", 32'(d_out), 32'(prev_exp));
            prev_exp = read_model(int'(addr), cyc);
            prev_oe  = d_oe;
            if (w_en) begin
                if (exp_q.size() == 0) begin
                    check("w_en_unexpected", 32'(w_en), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("w_addr", 32'(w_addr), 32'(e.addr));
                    check("w_data", 32'(w_data), 32'(e.data));
                    check("w_en_cycle", 32'(cyc), 32'(e.when));
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].when) begin
                check("w_en_missing", 32'(w_en), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, required finish within 200000 ns");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst  = 1'b1;
        phi2 = 1'b1;
        cs_n = 1'b0;
        rw   = 1'b0;
        addr = 5'd4;
        d_in = 8'h99;
        potx = 8'h11;
        poty = 8'h22;
        osc3 = 8'h33;
        env3 = 8'h44;

        // Reset asserted in the middle of a write cycle; nothing may commit.
        repeat (3) step();
        @(negedge clk);
        check("rst_w_en", 32'(w_en), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_d_oe", 32'(d_oe), 32'd0);
        step();
        rst = 1'b0;
        repeat (5) step();
        phi2 = 1'b0;
        repeat (8) step();

        bus_cycle(0, 0, 4, 8'h41, 3, 4, -1, 0);
        bus_cycle(0, 0, 24, 8'h1F, 4, 5, -1, 0);
        bus_cycle(0, 0, 26, 8'h55, 3, 4, -1, 0);
        bus_cycle(1, 0, 7, 0, 4, 4, -1, 0);

        osc3 = 8'hA5;
        bus_cycle(1, 0, 27, 0, 6, 4, 3, 8'h5A);

        // Decay: readable before expiry, zero after.
        bus_cycle(0, 0, 0, 8'hC3, 3, 4, -1, 0);
        bus_cycle(1, 0, 0, 0, 3, 4, -1, 0);
        repeat (10) step();
        bus_cycle(1, 0, 0, 0, 3, 4, -1, 0);

        // Second write commits exactly on the first write's expiry cycle;
        // the long read then spans the reloaded counter's own expiry.
        bus_cycle(0, 0, 3, 8'h12, 4, 4, -1, 0);
        bus_cycle(0, 0, 3, 8'h77, 4, 4, -1, 0);
        bus_cycle(1, 0, 9, 0, 12, 4, -1, 0);

        // Deselected write: no strobe, latch untouched.
        bus_cycle(0, 0, 30, 8'h6C, 3, 4, -1, 0);
        bus_cycle(0, 1, 5, 8'hEE, 3, 4, -1, 0);
        bus_cycle(1, 0, 5, 0, 3, 4, -1, 0);

        // Single-clk phi2 glitch still yields one sample and a commit.
        bus_cycle(0, 0, 12, 8'hB4, 1, 4, -1, 0);

        for (int n = 0; n < 80; n++) begin
            bit rw_r;
            bit cs_r;
            int a_r;
            rw_r = 1'($urandom_range(0, 1));
            cs_r = ($urandom_range(0, 5) == 0);
            a_r  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(25, 31)) : int'($urandom_range(0, 24));
            potx = 8'($urandom);
            poty = 8'($urandom);
            env3 = 8'($urandom);
            bus_cycle(rw_r, cs_r, a_r, int'($urandom_range(0, 255)),
                      int'($urandom_range(1, 6)), int'($urandom_range(4, 12)),
                      int'($urandom_range(0, 7)) - 2, int'($urandom_range(0, 255)));
        end

        repeat (12) step();
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_bus_if.md
Name: sid_bus_if

Overview:
- Upstream bus interface for the SID register file.
- Converts the asynchronous 6502-style host bus (phi2, cs_n, rw, addr, data) into single-cycle clk-domain write strobes (w_en/w_addr/w_data) that drive regFile.
- Provides read-back: addresses 25..28 return potx/poty/osc3/env3; all other addresses return a decaying bus-value latch, matching 6581 open-bus behaviour.

Parameters:
SYNC_STAGES, 2, flop depth of the phi2/cs_n/rw synchronizers (min 2)
DECAY_CYCLES, 2000000, clk cycles after the last write before the bus latch clears to 0x00
DECAY_W, 24, width of the decay counter; must hold DECAY_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
phi2  in  1  host bus clock, asynchronous to clk
cs_n  in  1  chip select, active-low, async
rw  in  1  1=read, 0=write, async
addr  in  5  register address, stable while phi2 high
d_in  in  8  host write data
d_out  out  8  host read data
d_oe  out  1  drive enable for the host data bus
potx  in  8  read-only reg 25
poty  in  8  read-only reg 26
osc3  in  8  read-only reg 27
env3  in  8  read-only reg 28
w_en  out  1  one-cycle write strobe to regFile
w_addr  out  5  write address, 0..24 only
w_data  out  8  write data

Behaviour:
- Reset values: w_en=0, w_addr=0, w_data=0, d_out=0, d_oe=0, bus latch=0x00, decay counter=0. Sync chains reset to phi2=0, cs_n=1, rw=1. FSM goes to WAIT_LOW.
- phi2, cs_n and rw pass through SYNC_STAGES flops. The results are phi2_s, cs_s, rw_s.
- FSM states:
  - WAIT_LOW: go to IDLE once phi2_s=0. This guarantees that no partial bus cycle commits after reset, including a reset asserted mid-cycle.
  - IDLE: go to ACTIVE on phi2_s=1.
  - ACTIVE: every clk, shadow-register addr, d_in, cs_s and rw_s. On phi2_s=0 go to COMMIT.
  - COMMIT: act on the shadow values, then go to IDLE (1 cycle).
- COMMIT with shadow cs=0 and rw=0 (write):
  - Bus latch <= shadow data; decay counter <= DECAY_CYCLES.
  - If addr <= 24: w_en=1 for exactly this one cycle, with w_addr/w_data = shadow values.
  - If addr 25..31: no w_en.
- Write latency: w_en rises SYNC_STAGES+1 clk edges after the first clk edge that samples phi2 low.
- w_addr and w_data hold their last value when w_en=0.
- Reads:
  - d_oe=1 only while state is ACTIVE and cs_s=0 and rw_s=1; otherwise 0.
  - d_out is registered from the current addr: 25->potx, 26->poty, 27->osc3, 28->env3, any other address->bus latch.
  - d_out updates every ACTIVE cycle, so read data tracks live potx..env3.
- Decay:
  - The counter decrements each clk while nonzero.
  - On the transition 1->0 the bus latch clears to 0x00.
  - A COMMIT write in the same cycle as that transition wins: the latch loads the new data and the counter reloads.
- Glitch handling: a phi2_s pulse of one clk still yields ACTIVE (1 shadow sample) then COMMIT.
- cs deasserted at the final ACTIVE sample means no write.
- rst has priority over every other action.

Decomposition:
- Shared package sid_pkg:
  - Address constants ADDR_POTX=25, ADDR_POTY=26, ADDR_OSC3=27, ADDR_ENV3=28.
  - NUM_WR_REGS=25.
  - Bus state enum {WAIT_LOW, IDLE, ACTIVE, COMMIT}.
  - These are reused by regFile.
- One sub-module, sid_sync: parameterised N-stage single-bit synchronizer. Instantiate it three times.

Test Plan:
- Hold phi2 high while asserting rst, then release -> no w_en on the following phi2 fall. The next full phi2 cycle writing addr=4, d=0x41 -> w_en=1 for exactly one cycle, w_addr=4, w_data=0x41.
- Write addr=24, d=0x1F -> w_en pulse with w_addr=24, w_data=0x1F, arriving SYNC_STAGES+1 clks after phi2 falls. Write addr=26, d=0x55 -> no w_en, but latch=0x55.
- Set osc3=0xA5 and read addr=27 -> d_oe=1 during phi2 high, d_out=0xA5. Change osc3 to 0x5A mid-phase -> d_out=0x5A the next cycle.
- With DECAY_CYCLES=8, write addr=0, d=0xC3, then read addr=0 -> 0xC3 while <8 clks have elapsed. After 8 clks a read returns 0x00.
- With DECAY_CYCLES=8, issue a write exactly on the decay expiry cycle, d=0x77 -> latch=0x77 and the counter reloads to 8.
- cs_n=1 during a phi2 cycle with rw=0 -> no w_en, d_oe=0, latch unchanged.
